// File: rtl/intra4_pred_gen_pkg.sv
// Shared definitions for the VP8 intra-4x4 predictor generator: mode encodings,
// FSM states, rounding averages and the pixel packing helper.
`ifndef I4_PIX_LSB
`define I4_PIX_LSB(x, y) (32 * (y) + 8 * (x))
`endif

package intra4_pred_gen_pkg;

  localparam int unsigned NUM_I4_MODES = 10;

  typedef enum logic [3:0] {
    B_DC = 4'd0,
    B_TM = 4'd1,
    B_VE = 4'd2,
    B_HE = 4'd3,
    B_RD = 4'd4,
    B_VR = 4'd5,
    B_LD = 4'd6,
    B_VL = 4'd7,
    B_HD = 4'd8,
    B_HU = 4'd9
  } b_mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCapt = 2'd1,
    StEmit = 2'd2
  } i4_state_e;

  // (a + 2b + c + 2) >> 2, carried on 10 bits
  function automatic logic [7:0] avg3(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    logic [9:0] s;
    s = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c} + 10'd2;
    return s[9:2];
  endfunction

  // (a + b + 1) >> 1, carried on 9 bits
  function automatic logic [7:0] avg2(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return s[8:1];
  endfunction

endpackage

// File: rtl/intra4_pred_mode.sv
// Combinational VP8 intra-4x4 predictor: one of the ten B_* modes from the
// left column, top-left, top row and top-right row.
module intra4_pred_mode
  import intra4_pred_gen_pkg::*;
(
  input  logic [3:0]   mode,
  input  logic [31:0]  left,
  input  logic [7:0]   top_left,
  input  logic [31:0]  top,
  input  logic [31:0]  top_right,
  output logic [127:0] pred
);

  logic [7:0]  t [4];
  logic [7:0]  e [4];
  logic [7:0]  l [4];
  logic [7:0]  tl;
  logic [7:0]  rd_d [8];
  logic [7:0]  ld_d [8];
  logic [10:0] dc_sum;
  logic [7:0]  dc_val;
  logic [9:0]  tm;
  logic [7:0]  p [4][4];  // [y][x]

  always_comb begin
    tl = top_left;
    for (int i = 0; i < 4; i++) begin
      t[i] = top[8*i +: 8];
      e[i] = top_right[8*i +: 8];
      l[i] = left[8*i +: 8];
    end
  end

  // Diagonal values shared by RD (indexed 3+x-y) and LD (indexed x+y)
  always_comb begin
    rd_d[0] = avg3(l[3], l[2], l[1]);
    rd_d[1] = avg3(l[2], l[1], l[0]);
    rd_d[2] = avg3(l[1], l[0], tl);
    rd_d[3] = avg3(l[0], tl, t[0]);
    rd_d[4] = avg3(tl, t[0], t[1]);
    rd_d[5] = avg3(t[0], t[1], t[2]);
    rd_d[6] = avg3(t[1], t[2], t[3]);
    rd_d[7] = '0;
    ld_d[0] = avg3(t[0], t[1], t[2]);
    ld_d[1] = avg3(t[1], t[2], t[3]);
    ld_d[2] = avg3(t[2], t[3], e[0]);
    ld_d[3] = avg3(t[3], e[0], e[1]);
    ld_d[4] = avg3(e[0], e[1], e[2]);
    ld_d[5] = avg3(e[1], e[2], e[3]);
    ld_d[6] = avg3(e[2], e[3], e[3]);
    ld_d[7] = '0;
    dc_sum = 11'd4;
    for (int i = 0; i < 4; i++) begin
      dc_sum = dc_sum + 11'(t[i]) + 11'(l[i]);
    end
    dc_val = dc_sum[10:3];
  end

  always_comb begin
    tm = '0;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        p[y][x] = '0;
      end
    end
    unique case (mode)
      B_DC: begin
        for (int y = 0; y < 4; y++) begin
          for (int x = 0; x < 4; x++) p[y][x] = dc_val;
        end
      end
      B_TM: begin
        for (int y = 0; y < 4; y++) begin
          for (int x = 0; x < 4; x++) begin
            tm = 10'(t[x]) + 10'(l[y]) - 10'(tl);
            // bit 9 flags a negative result, bit 8 an overflow past 255
            p[y][x] = tm[9] ? 8'h00 : (tm[8] ? 8'hFF : tm[7:0]);
          end
        end
      end
      B_VE: begin
        for (int y = 0; y < 4; y++) begin
          p[y][0] = avg3(tl, t[0], t[1]);
          p[y][1] = avg3(t[0], t[1], t[2]);
          p[y][2] = avg3(t[1], t[2], t[3]);
          p[y][3] = avg3(t[2], t[3], e[0]);
        end
      end
      B_HE: begin
        for (int x = 0; x < 4; x++) begin
          p[0][x] = avg3(tl, l[0], l[1]);
          p[1][x] = avg3(l[0], l[1], l[2]);
          p[2][x] = avg3(l[1], l[2], l[3]);
          p[3][x] = avg3(l[2], l[3], l[3]);
        end
      end
      B_RD: begin
        for (int y = 0; y < 4; y++) begin
          for (int x = 0; x < 4; x++) p[y][x] = rd_d[3'(3 + x - y)];
        end
      end
      B_VR: begin
        p[0][0] = avg2(tl, t[0]);
        p[2][1] = avg2(tl, t[0]);
        p[0][1] = avg2(t[0], t[1]);
        p[2][2] = avg2(t[0], t[1]);
        p[0][2] = avg2(t[1], t[2]);
        p[2][3] = avg2(t[1], t[2]);
        p[0][3] = avg2(t[2], t[3]);
        p[1][0] = avg3(l[0], tl, t[0]);
        p[3][1] = avg3(l[0], tl, t[0]);
        p[1][1] = avg3(tl, t[0], t[1]);
        p[3][2] = avg3(tl, t[0], t[1]);
        p[1][2] = avg3(t[0], t[1], t[2]);
        p[3][3] = avg3(t[0], t[1], t[2]);
        p[1][3] = avg3(t[1], t[2], t[3]);
        p[2][0] = avg3(l[1], l[0], tl);
        p[3][0] = avg3(l[2], l[1], l[0]);
      end
      B_LD: begin
        for (int y = 0; y < 4; y++) begin
          for (int x = 0; x < 4; x++) p[y][x] = ld_d[3'(x + y)];
        end
      end
      B_VL: begin
        p[0][0] = avg2(t[0], t[1]);
        p[1][0] = avg3(t[0], t[1], t[2]);
        p[2][0] = avg2(t[1], t[2]);
        p[0][1] = avg2(t[1], t[2]);
        p[1][1] = avg3(t[1], t[2], t[3]);
        p[3][0] = avg3(t[1], t[2], t[3]);
        p[2][1] = avg2(t[2], t[3]);
        p[0][2] = avg2(t[2], t[3]);
        p[3][1] = avg3(t[2], t[3], e[0]);
        p[1][2] = avg3(t[2], t[3], e[0]);
        p[0][3] = avg2(t[3], e[0]);
        p[2][2] = avg2(t[3], e[0]);
        p[1][3] = avg3(t[3], e[0], e[1]);
        p[3][2] = avg3(t[3], e[0], e[1]);
        // VP8 departs from the H.264 pattern on these two pixels
        p[2][3] = avg3(e[0], e[1], e[2]);
        p[3][3] = avg3(e[1], e[2], e[3]);
      end
      B_HD: begin
        p[3][0] = avg2(l[3], l[2]);
        p[3][1] = avg3(l[3], l[2], l[1]);
        p[2][0] = avg2(l[2], l[1]);
        p[3][2] = avg2(l[2], l[1]);
        p[2][1] = avg3(l[2], l[1], l[0]);
        p[3][3] = avg3(l[2], l[1], l[0]);
        p[2][2] = avg2(l[1], l[0]);
        p[1][0] = avg2(l[1], l[0]);
        p[2][3] = avg3(l[1], l[0], tl);
        p[1][1] = avg3(l[1], l[0], tl);
        p[1][2] = avg2(l[0], tl);
        p[0][0] = avg2(l[0], tl);
        p[1][3] = avg3(l[0], tl, t[0]);
        p[0][1] = avg3(l[0], tl, t[0]);
        p[0][2] = avg3(tl, t[0], t[1]);
        p[0][3] = avg3(t[0], t[1], t[2]);
      end
      B_HU: begin
        p[0][0] = avg2(l[0], l[1]);
        p[0][1] = avg3(l[0], l[1], l[2]);
        p[0][2] = avg2(l[1], l[2]);
        p[1][0] = avg2(l[1], l[2]);
        p[0][3] = avg3(l[1], l[2], l[3]);
        p[1][1] = avg3(l[1], l[2], l[3]);
        p[1][2] = avg2(l[2], l[3]);
        p[2][0] = avg2(l[2], l[3]);
        p[1][3] = avg3(l[2], l[3], l[3]);
        p[2][1] = avg3(l[2], l[3], l[3]);
        p[2][2] = l[3];
        p[2][3] = l[3];
        for (int x = 0; x < 4; x++) p[3][x] = l[3];
      end
      default: ;
    endcase
  end

  always_comb begin
    pred = '0;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) pred[`I4_PIX_LSB(x, y) +: 8] = p[y][x];
    end
  end

endmodule

// File: rtl/intra4_pred_gen.sv
// Captures one I4 neighbour set and streams its ten intra-4x4 predictors,
// one mode per accepted beat, with a registered prediction output.
module intra4_pred_gen
  import intra4_pred_gen_pkg::*;
#(
  parameter int unsigned NUM_MODES = NUM_I4_MODES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [4:0]   i4,
  input  logic [31:0]  left_i,
  input  logic [7:0]   top_left_i,
  input  logic [31:0]  top_i,
  input  logic [31:0]  top_right_i,
  output logic         busy,
  output logic         pred_valid,
  input  logic         pred_ready,
  output logic [3:0]   pred_mode,
  output logic [4:0]   pred_i4,
  output logic [127:0] pred_data,
  output logic         pred_last
);

  localparam logic [3:0] LastMode = 4'(NUM_MODES - 1);

  i4_state_e    state_q, state_d;
  logic [3:0]   mode_cnt_q;
  logic [31:0]  left_q, top_q, tr_q;
  logic [7:0]   tl_q;
  logic [4:0]   i4_q;
  logic [127:0] pred_data_q;
  logic [3:0]   gen_mode;
  logic [127:0] gen_pred;
  logic         xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StCapt;
      StCapt:  state_d = StEmit;
      StEmit:  if (pred_ready && (mode_cnt_q == LastMode)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy       = (state_q != StIdle);
    pred_valid = (state_q == StEmit);
    pred_last  = (state_q == StEmit) && (mode_cnt_q == LastMode);
    pred_mode  = mode_cnt_q;
    pred_i4    = i4_q;
    pred_data  = pred_data_q;
  end

  // The predictor is always prepared for the beat after the one on the wire
  always_comb begin
    xfer     = (state_q == StEmit) && pred_ready;
    gen_mode = (state_q == StCapt) ? 4'd0 : mode_cnt_q + 4'd1;
  end

  intra4_pred_mode u_pred_mode (
    .mode      (gen_mode),
    .left      (left_q),
    .top_left  (tl_q),
    .top       (top_q),
    .top_right (tr_q),
    .pred      (gen_pred)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_cnt_q  <= '0;
      left_q      <= '0;
      top_q       <= '0;
      tr_q        <= '0;
      tl_q        <= '0;
      i4_q        <= '0;
      pred_data_q <= '0;
    end else begin
      if ((state_q == StIdle) && start) begin
        left_q <= left_i;
        top_q  <= top_i;
        tr_q   <= top_right_i;
        tl_q   <= top_left_i;
        i4_q   <= i4;
      end
      if (state_q == StCapt) begin
        mode_cnt_q  <= '0;
        pred_data_q <= gen_pred;
      end else if (xfer) begin
        mode_cnt_q  <= (mode_cnt_q == LastMode) ? 4'd0 : mode_cnt_q + 4'd1;
        pred_data_q <= gen_pred;
      end
    end
  end

endmodule
